// File: rtl/fp_regs_pkg.sv
// Shared constants, index type and reset-value helper for the FP register file.
package fp_regs_pkg;

    localparam int FP_XLEN  = 32;
    localparam int FP_NREGS = 32;
    localparam int FP_NREAD = 3;

    // Register index for the default-sized file.
    typedef logic [$clog2(FP_NREGS)-1:0] fpRegIdx_t;

    // Value every FP register takes on reset (+0.0).
    function automatic logic [FP_XLEN-1:0] fpResetValue();
        return '0;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, writeback releases it.
// pendingCount tracks the popcount of the busy vector as a registered counter.
module fp_scoreboard
    import fp_regs_pkg::*;
#(
    parameter int NREGS = FP_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issueValid,
    input  logic [AW-1:0]    issueRegister,
    output logic             issueReady,
    input  logic             regWrite,
    input  logic [AW-1:0]    writeRegister,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pendingCount
);

    logic [NREGS-1:0] busyReg;
    logic [NREGS-1:0] busyNext;
    logic [AW:0]      pendingReg;
    logic [AW:0]      pendingNext;
    logic             writeHit;
    logic             issueAccept;
    logic             countUp;
    logic             countDown;

    // Handshake, next busy vector and counter delta; a same-register issue overrides the release.
    always_comb begin
        writeHit    = regWrite && (writeRegister == issueRegister);
        issueReady  = !busyReg[issueRegister] || writeHit;
        issueAccept = issueValid && issueReady;
        countUp     = issueAccept && !busyReg[issueRegister];
        countDown   = regWrite && busyReg[writeRegister] && !(issueAccept && writeHit);

        busyNext = busyReg;
        if (regWrite) begin
            busyNext[writeRegister] = 1'b0;
        end
        if (issueAccept) begin
            busyNext[issueRegister] = 1'b1;
        end

        pendingNext = pendingReg;
        case ({countUp, countDown})
            2'b10:   pendingNext = pendingReg + (AW+1)'(1);
            2'b01:   pendingNext = pendingReg - (AW+1)'(1);
            default: pendingNext = pendingReg;
        endcase
    end

    // Busy vector and pending counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busyReg    <= '0;
            pendingReg <= '0;
        end else begin
            busyReg    <= busyNext;
            pendingReg <= pendingNext;
        end
    end

    assign busy         = busyReg;
    assign pendingCount = pendingReg;

endmodule

// File: rtl/registers_fp_sb.sv
// Parametrised FP register file with busy scoreboard and asynchronous reset.
// Optional WRITE_BYPASS_EN: a same-cycle write is forwarded to matching read ports,
// which also see the register as not busy.
module registers_fp_sb
    import fp_regs_pkg::*;
#(
    parameter int XLEN  = FP_XLEN,
    parameter int NREGS = FP_NREGS,
    parameter int NREAD = FP_NREAD,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   readRegister,
    output logic [NREAD*XLEN-1:0] readData,
    output logic [NREAD-1:0]      readBusy,
    input  logic                  issueValid,
    input  logic [AW-1:0]         issueRegister,
    output logic                  issueReady,
    input  logic                  regWrite,
    input  logic [AW-1:0]         writeRegister,
    input  logic [XLEN-1:0]       writeData,
    output logic [AW:0]           pendingCount
);

    logic [XLEN-1:0]  regFile [NREGS];
    logic [NREGS-1:0] busyVec;

    // Data array: cleared on reset, one write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= XLEN'(fpResetValue());
            end
        end else if (regWrite) begin
            regFile[writeRegister] <= writeData;
        end
    end

    fp_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issueValid    (issueValid),
        .issueRegister (issueRegister),
        .issueReady    (issueReady),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .busy          (busyVec),
        .pendingCount  (pendingCount)
    );

    // Combinational read ports, each with its own busy lookup.
    for (genvar gi = 0; gi < NREAD; gi++) begin : gRead
        logic [AW-1:0] rdIdx;
        assign rdIdx = readRegister[gi*AW +: AW];
`ifdef WRITE_BYPASS_EN
        logic bypassHit;
        assign bypassHit = regWrite && (writeRegister == rdIdx);
        assign readData[gi*XLEN +: XLEN] = bypassHit ? writeData : regFile[rdIdx];
        assign readBusy[gi] = busyVec[rdIdx] && !bypassHit;
`else
        assign readData[gi*XLEN +: XLEN] = regFile[rdIdx];
        assign readBusy[gi] = busyVec[rdIdx];
`endif
    end

endmodule
